// File: rtl/id_stage.sv
// rtl/id_stage.sv - ARM968E-S decode stage: instruction decode, condition check, register file, SR, ID/EX register
module id_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_in,
    input  logic [31:0] instruction_in,
    input  logic        hazard,
    input  logic        flush,
    input  logic        wb_en,
    input  logic [3:0]  wb_dest,
    input  logic [31:0] wb_value,
    input  logic [3:0]  status_in,
    input  logic        status_wr,
    output logic [3:0]  src1,
    output logic [3:0]  src2,
    output logic        two_src,
    output logic [31:0] pc_out,
    output logic [31:0] val_rn,
    output logic [31:0] val_rm,
    output logic [3:0]  dest,
    output logic [3:0]  exe_cmd,
    output logic        mem_r,
    output logic        mem_w,
    output logic        wb_en_out,
    output logic        b,
    output logic        s,
    output logic        imm,
    output logic [11:0] shift_operand,
    output logic [23:0] signed_imm24,
    output logic [3:0]  status_out
);

    // Instruction fields
    logic [3:0]  w_cond;
    logic [1:0]  w_mode;
    logic        w_i;
    logic [3:0]  w_opcode;
    logic        w_s_bit;
    logic [3:0]  w_rn;
    logic [3:0]  w_rd;
    logic [3:0]  w_rm;
    logic [11:0] w_shift;
    logic [23:0] w_imm24;

    assign w_cond   = instruction_in[31:28];
    assign w_mode   = instruction_in[27:26];
    assign w_i      = instruction_in[25];
    assign w_opcode = instruction_in[24:21];
    assign w_s_bit  = instruction_in[20];
    assign w_rn     = instruction_in[19:16];
    assign w_rd     = instruction_in[15:12];
    assign w_shift  = instruction_in[11:0];
    assign w_rm     = instruction_in[3:0];
    assign w_imm24  = instruction_in[23:0];

    // State: R0-R14 and NZCV
    logic [31:0] r_regs [0:14];
    logic [3:0]  r_sr;

    // Effective flags: a flag-setting instruction in execute is seen by decode in the same cycle
    logic [3:0] w_nzcv;
    assign w_nzcv = status_wr ? status_in : r_sr;

    logic w_is_str;
    logic w_is_mov_mvn;
    assign w_is_str     = (w_mode == 2'b01) && !w_s_bit;
    assign w_is_mov_mvn = (w_opcode == 4'b1101) || (w_opcode == 4'b1111);

    // Source indices for the hazard unit, straight from the fetched instruction
    assign src1    = w_rn;
    assign src2    = w_is_str ? w_rd : w_rm;
    assign two_src = ((w_mode == 2'b00) && !w_i && !w_is_mov_mvn) || w_is_str;

    // Condition evaluation on effective NZCV
    logic w_cond_ok;
    always_comb begin
        logic n, z, c, v;
        n = w_nzcv[3];
        z = w_nzcv[2];
        c = w_nzcv[1];
        v = w_nzcv[0];
        w_cond_ok = 1'b0;
        case (w_cond)
            4'b0000: w_cond_ok = z;
            4'b0001: w_cond_ok = !z;
            4'b0010: w_cond_ok = c;
            4'b0011: w_cond_ok = !c;
            4'b0100: w_cond_ok = n;
            4'b0101: w_cond_ok = !n;
            4'b0110: w_cond_ok = v;
            4'b0111: w_cond_ok = !v;
            4'b1000: w_cond_ok = c && !z;
            4'b1001: w_cond_ok = !c || z;
            4'b1010: w_cond_ok = (n == v);
            4'b1011: w_cond_ok = (n != v);
            4'b1100: w_cond_ok = !z && (n == v);
            4'b1101: w_cond_ok = z || (n != v);
            4'b1110: w_cond_ok = 1'b1;
            default: w_cond_ok = 1'b0;
        endcase
    end

    // Opcode decode into execute command and control bits; w_valid marks supported encodings
    logic [3:0] w_cmd;
    logic       w_mem_r;
    logic       w_mem_w;
    logic       w_wb;
    logic       w_b;
    logic       w_s;
    logic       w_valid;
    always_comb begin
        w_cmd   = 4'b0000;
        w_mem_r = 1'b0;
        w_mem_w = 1'b0;
        w_wb    = 1'b0;
        w_b     = 1'b0;
        w_s     = 1'b0;
        w_valid = 1'b0;
        case (w_mode)
            2'b00: begin
                w_valid = 1'b1;
                w_wb    = 1'b1;
                w_s     = w_s_bit;
                case (w_opcode)
                    4'b1101: w_cmd = 4'b0001;
                    4'b1111: w_cmd = 4'b1001;
                    4'b0100: w_cmd = 4'b0010;
                    4'b0101: w_cmd = 4'b0011;
                    4'b0010: w_cmd = 4'b0100;
                    4'b0110: w_cmd = 4'b0101;
                    4'b0000: w_cmd = 4'b0110;
                    4'b1100: w_cmd = 4'b0111;
                    4'b0001: w_cmd = 4'b1000;
                    4'b1010: begin
                        w_cmd = 4'b0100;
                        w_wb  = 1'b0;
                        w_s   = 1'b1;
                    end
                    4'b1000: begin
                        w_cmd = 4'b0110;
                        w_wb  = 1'b0;
                        w_s   = 1'b1;
                    end
                    default: begin
                        w_valid = 1'b0;
                        w_wb    = 1'b0;
                        w_s     = 1'b0;
                    end
                endcase
            end
            2'b01: begin
                w_valid = 1'b1;
                w_cmd   = 4'b0010;
                w_mem_r = w_s_bit;
                w_mem_w = !w_s_bit;
                w_wb    = w_s_bit;
            end
            2'b10: begin
                w_valid = 1'b1;
                w_b     = 1'b1;
            end
            default: w_valid = 1'b0;
        endcase
    end

    logic w_bubble;
    assign w_bubble = flush || hazard || !w_cond_ok || !w_valid;

    // Register file read for Rn: R15 is the PC, otherwise write-through bypass then stored value
    logic [31:0] w_rn_val;
    always_comb begin
        w_rn_val = 32'd0;
        if (w_rn == 4'd15)
            w_rn_val = pc_in;
        else if (wb_en && (wb_dest == w_rn))
            w_rn_val = wb_value;
        else
            w_rn_val = r_regs[w_rn];
    end

    // Register file read for src2 (Rm, or Rd for STR so the store data is available)
    logic [31:0] w_rm_val;
    always_comb begin
        w_rm_val = 32'd0;
        if (src2 == 4'd15)
            w_rm_val = pc_in;
        else if (wb_en && (wb_dest == src2))
            w_rm_val = wb_value;
        else
            w_rm_val = r_regs[src2];
    end

    // Register file write; R15 writes are dropped
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 15; i++)
                r_regs[i] <= 32'd0;
        end else if (wb_en && (wb_dest != 4'd15)) begin
            r_regs[wb_dest] <= wb_value;
        end
    end

    // Status register update from execute
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_sr <= 4'd0;
        else if (status_wr)
            r_sr <= status_in;
    end

    // ID/EX pipeline register: data fields always load, control bits cleared on a bubble
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_out        <= 32'd0;
            val_rn        <= 32'd0;
            val_rm        <= 32'd0;
            dest          <= 4'd0;
            exe_cmd       <= 4'd0;
            mem_r         <= 1'b0;
            mem_w         <= 1'b0;
            wb_en_out     <= 1'b0;
            b             <= 1'b0;
            s             <= 1'b0;
            imm           <= 1'b0;
            shift_operand <= 12'd0;
            signed_imm24  <= 24'd0;
            status_out    <= 4'd0;
        end else begin
            pc_out        <= pc_in;
            val_rn        <= w_rn_val;
            val_rm        <= w_rm_val;
            dest          <= w_rd;
            imm           <= w_i;
            shift_operand <= w_shift;
            signed_imm24  <= w_imm24;
            status_out    <= w_nzcv;
            if (w_bubble) begin
                exe_cmd   <= 4'd0;
                mem_r     <= 1'b0;
                mem_w     <= 1'b0;
                wb_en_out <= 1'b0;
                b         <= 1'b0;
                s         <= 1'b0;
            end else begin
                exe_cmd   <= w_cmd;
                mem_r     <= w_mem_r;
                mem_w     <= w_mem_w;
                wb_en_out <= w_wb;
                b         <= w_b;
                s         <= w_s;
            end
        end
    end

endmodule
